// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the 16x32 register file
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF = 16;
  localparam int AW = 4;
  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;
  localparam reg_addr_t ZERO_ADDR = 4'd0;
endpackage

// File: rtl/regfile_16x32_if.sv
// regfile_16x32_if: write-back, operand-read and debug signals of the register file
interface regfile_16x32_if #(
  parameter int DATA_W = 32,
  parameter int NREG = 16,
  parameter int CNT_W = 16
);
  import regfile_pkg::*;
  logic we;
  reg_addr_t waddr;
  logic [DATA_W-1:0] wdata;
  reg_addr_t raddr1;
  reg_addr_t raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [NREG-1:0] valid_map;
  logic [CNT_W-1:0] wr_count;
  modport master (output we, waddr, wdata, raddr1, raddr2, input rdata1, rdata2, valid_map, wr_count);
  modport slave (input we, waddr, wdata, raddr1, raddr2, output rdata1, rdata2, valid_map, wr_count);
endinterface

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port with r0 forcing
// and, under REGFILE_WRITE_BYPASS_EN, same-cycle write-through from the write port
module regfile_rd_port import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG = NREG_DEF,
  parameter int ZERO_REG = 1
) (
  input logic [NREG-1:0][DATA_W-1:0] regs,
  input reg_addr_t raddr,
`ifdef REGFILE_WRITE_BYPASS_EN
  input logic we,
  input reg_addr_t waddr,
  input logic [DATA_W-1:0] wdata,
`endif
  output logic [DATA_W-1:0] rdata
);
  logic is_zero;
  assign is_zero = (ZERO_REG != 0) && (raddr == ZERO_ADDR);
`ifdef REGFILE_WRITE_BYPASS_EN
  // r0 forcing takes priority, so a suppressed r0 write is never forwarded
  always_comb rdata = is_zero ? '0 : (we && waddr == raddr) ? wdata : regs[raddr];
`else
  always_comb rdata = is_zero ? '0 : regs[raddr];
`endif
endmodule

// File: rtl/regfile_16x32.sv
// regfile_16x32: MIPS-style 2R1W register file with written-since-reset bitmap and write counter
// optional same-cycle write bypass when REGFILE_WRITE_BYPASS_EN is defined
module regfile_16x32 import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG = NREG_DEF,
  parameter int ZERO_REG = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  regfile_16x32_if.slave bus
);
  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0] valid_map;
  logic [CNT_W-1:0] wr_count;
  logic commit;
  assign commit = bus.we && !((ZERO_REG != 0) && (bus.waddr == ZERO_ADDR));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      regs <= '0;
      valid_map <= NREG'(ZERO_REG != 0);
      wr_count <= '0;
    end else if (commit) begin
      regs[bus.waddr] <= bus.wdata;
      valid_map[bus.waddr] <= 1'b1;
      wr_count <= wr_count + CNT_W'(1);
    end
  assign bus.valid_map = valid_map;
  assign bus.wr_count = wr_count;
  regfile_rd_port #(.DATA_W(DATA_W), .NREG(NREG), .ZERO_REG(ZERO_REG)) u_rd1 (
    .regs(regs),
    .raddr(bus.raddr1),
`ifdef REGFILE_WRITE_BYPASS_EN
    .we(commit),
    .waddr(bus.waddr),
    .wdata(bus.wdata),
`endif
    .rdata(bus.rdata1)
  );
  regfile_rd_port #(.DATA_W(DATA_W), .NREG(NREG), .ZERO_REG(ZERO_REG)) u_rd2 (
    .regs(regs),
    .raddr(bus.raddr2),
`ifdef REGFILE_WRITE_BYPASS_EN
    .we(commit),
    .waddr(bus.waddr),
    .wdata(bus.wdata),
`endif
    .rdata(bus.rdata2)
  );
endmodule

// File: tb/tb_regfile_16x32.sv
// tb_regfile_16x32: directed scoreboard bench for regfile_16x32 (default and 4-bit-counter instances)
module tb_regfile_16x32;
  typedef struct {
    string name;
    int sel;
    logic [31:0] exp;
  } item_t;

  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  item_t q[$];

  always #5 clk = ~clk;

  regfile_16x32_if #(.DATA_W(32), .NREG(16), .CNT_W(16)) bus ();
  regfile_16x32_if #(.DATA_W(32), .NREG(16), .CNT_W(4)) bus4 ();

  regfile_16x32 #(.DATA_W(32), .NREG(16), .ZERO_REG(1), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  regfile_16x32 #(.DATA_W(32), .NREG(16), .ZERO_REG(1), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0: return bus.rdata1;
      1: return bus.rdata2;
      2: return {16'h0, bus.valid_map};
      3: return {16'h0, bus.wr_count};
      default: return {28'h0, bus4.wr_count};
    endcase
  endfunction

  task automatic expect_val(string name, int sel, logic [31:0] exp);
    item_t it;
    it.name = name;
    it.sel = sel;
    it.exp = exp;
    q.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: everything queued during a cycle is compared at the following falling edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      item_t it;
      logic [31:0] act;
      it = q.pop_front();
      act = observe(it.sel);
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  initial begin
    bus.we = 0; bus.waddr = 0; bus.wdata = 0; bus.raddr1 = 0; bus.raddr2 = 0;
    bus4.we = 0; bus4.waddr = 0; bus4.wdata = 0; bus4.raddr1 = 0; bus4.raddr2 = 0;
    #1;
    expect_val("reset_rdata1", 0, 32'h0);
    expect_val("reset_valid_map", 2, 32'h0001);
    expect_val("reset_wr_count", 3, 32'h0);
    expect_val("reset_wr_count4", 4, 32'h0);
    step();
    rst = 0;
    // basic write/read
    bus.we = 1; bus.waddr = 4'd5; bus.wdata = 32'hDEADBEEF;
    step();
    bus.we = 0; bus.raddr1 = 4'd5;
    expect_val("wr5_rdata1", 0, 32'hDEADBEEF);
    expect_val("wr5_valid_map", 2, 32'h0021);
    expect_val("wr5_wr_count", 3, 32'h1);
    step();
    // r0 protection, including no forwarding of the suppressed write
    bus.we = 1; bus.waddr = 4'd0; bus.wdata = 32'hFFFFFFFF; bus.raddr1 = 4'd0;
    expect_val("r0_same_cycle", 0, 32'h0);
    step();
    bus.we = 0;
    expect_val("r0_rdata1", 0, 32'h0);
    expect_val("r0_wr_count", 3, 32'h1);
    expect_val("r0_valid_map", 2, 32'h0021);
    step();
    // both ports on the same register
    bus.raddr1 = 4'd5; bus.raddr2 = 4'd5;
    expect_val("dual_rdata1", 0, 32'hDEADBEEF);
    expect_val("dual_rdata2", 1, 32'hDEADBEEF);
    step();
    // same-cycle read-after-write on r3
    bus.we = 1; bus.waddr = 4'd3; bus.wdata = 32'h11;
    step();
    bus.wdata = 32'h22; bus.raddr2 = 4'd3;
`ifdef REGFILE_WRITE_BYPASS_EN
    expect_val("raw_before_edge", 1, 32'h22);
`else
    expect_val("raw_before_edge", 1, 32'h11);
`endif
    step();
    bus.we = 0;
    expect_val("raw_after_edge", 1, 32'h22);
    expect_val("raw_wr_count", 3, 32'h3);
    expect_val("raw_valid_map", 2, 32'h0029);
    step();
    // we=0 must not change state
    bus.waddr = 4'd6; bus.wdata = 32'h123;
    step();
    bus.raddr1 = 4'd6;
    expect_val("we0_rdata1", 0, 32'h0);
    expect_val("we0_wr_count", 3, 32'h3);
    expect_val("we0_valid_map", 2, 32'h0029);
    step();
    // asynchronous reset with live contents, sampled before any rising edge
    bus.raddr1 = 4'd5; bus.raddr2 = 4'd3; rst = 1;
    expect_val("arst_rdata1", 0, 32'h0);
    expect_val("arst_rdata2", 1, 32'h0);
    expect_val("arst_valid_map", 2, 32'h0001);
    expect_val("arst_wr_count", 3, 32'h0);
    step();
    rst = 0;
    // write held on r7 while reset spans an edge
    bus.we = 1; bus.waddr = 4'd7; bus.wdata = 32'hAA;
    step();
    rst = 1;
    step();
    rst = 0; bus.we = 0; bus.raddr1 = 4'd7;
    expect_val("midrst_rdata1", 0, 32'h0);
    expect_val("midrst_valid_map", 2, 32'h0001);
    expect_val("midrst_wr_count", 3, 32'h0);
    step();
    // 4-bit counter: 17 committed writes plus one suppressed r0 write
    bus4.we = 1;
    for (int i = 0; i < 17; i++) begin
      bus4.waddr = 4'((i % 15) + 1); bus4.wdata = 32'(i);
      step();
    end
    bus4.waddr = 4'd0;
    step();
    bus4.we = 0;
    expect_val("wrap_wr_count4", 4, 32'h1);
    step();
    step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
